// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the transmit state encoding.
package uart_tx_pkg;

  localparam logic [31:0] TXDATA_OFFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFFS = 32'h0000_0004;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Counter-based synchronous FIFO. Pushes while full and pops while empty
// are ignored, so the caller may issue them unconditionally. Storage has
// no reset; only pointers and count are cleared, which discards contents.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA are queued in a
// FIFO that the transmit FSM drains at the baud rate; STATUS exposes the
// FIFO and transmitter state. A TXDATA store to a full FIFO is stalled by
// withholding mem_ready until a slot frees up.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int SYSTEM_CLK = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx
);

  localparam int DIV = SYSTEM_CLK / BAUDRATE;
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_mmio: SYSTEM_CLK / BAUDRATE must be at least 2");
  end

  tx_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        baud_tick;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  logic        is_status;
  logic        is_write;
  logic        push_req;
  logic        accept;
  logic [31:0] status_word;

  logic        unused_bits;
  assign unused_bits = ^{mem_addr[31:3], mem_addr[1:0], mem_wdata[31:8]};

  // Only address bit 2 distinguishes the two registers; block select is external.
  assign is_status = (mem_addr[2] == STATUS_OFFS[2]);
  assign is_write  = (mem_wstrb != 4'b0000);
  assign push_req  = !is_status && mem_wstrb[0];

  // Never accept while the previous ack is showing, and hold off a push
  // into a full FIFO so it is retried every cycle.
  assign accept    = mem_valid && !mem_ready && !(push_req && fifo_full);
  assign fifo_push = accept && push_req;

  assign baud_tick = (state != IDLE) && (baud_cnt == '0);
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_tick));

  // Assemble the STATUS register from the current registered state.
  always_comb begin
    status_word                 = '0;
    status_word[STAT_FULL_BIT]  = fifo_full;
    status_word[STAT_EMPTY_BIT] = fifo_empty;
    status_word[STAT_BUSY_BIT]  = (state != IDLE);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (mem_wdata[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Bus response: one-cycle ack after accept; read data only for STATUS reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      if (accept && is_status && !is_write) mem_rdata <= status_word;
      else                                  mem_rdata <= '0;
    end
  end

  // Transmit FSM with baud counter and LSB-first shift register; STOP chains
  // straight into the next START when more data is queued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift    <= fifo_dout;
            baud_cnt <= DIV_M1;
            state    <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            baud_cnt <= DIV_M1;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_cnt <= DIV_M1;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (!fifo_empty) begin
              shift    <= fifo_dout;
              baud_cnt <= DIV_M1;
              state    <= START;
            end else begin
              baud_cnt <= '0;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line level decoded from state so reset forces the idle level at once.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio with DIV = 10. Bus responses and
// expected serial frames are queued by the stimulus and checked by two
// independent monitor processes.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] data;
    bit         contig;
  } frame_t;

  frame_t      tx_q[$];
  logic [31:0] rd_q[$];

  uart_tx_mmio #(
    .SYSTEM_CLK (1000),
    .BAUDRATE   (100),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx)
  );

  // 100 MHz-style free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // One bus transaction; expected read data goes to the scoreboard first.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               output int waited);
    if (mem_ready) begin
      @(posedge clk); #1;
    end
    rd_q.push_back(exp_rdata);
    mem_addr  = addr;
    mem_wstrb = strb;
    mem_wdata = wdata;
    mem_valid = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!mem_ready && waited < 2000);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    if (!mem_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL bus_timeout: got no mem_ready after %0d cycles, expected an ack", waited);
      void'(rd_q.pop_back());
    end
  endtask

  // Bus monitor: pops the scoreboard on every ack and checks idle rdata.
  initial begin : bus_mon
    logic        prev_ready;
    logic [31:0] exp_v;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        checkOutput("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
        if (rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_ready: got ack with rdata 0x%08h, expected none", mem_rdata);
        end else begin
          exp_v = rd_q.pop_front();
          checkOutput("rdata", mem_rdata, exp_v);
        end
      end else begin
        checkOutput("rdata_idle_zero", mem_rdata, 32'd0);
      end
      prev_ready = mem_ready;
    end
  end

  // Serial monitor: decodes each frame cycle by cycle and checks it
  // against the next expected frame; frames cut by reset are dropped.
  initial begin : uart_mon
    int         start_cyc;
    int         prev_start;
    logic [9:0] bits;
    bit         aborted;
    bit         stable;
    frame_t     expf;
    prev_start = -1000;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        start_cyc = cyc;
        aborted   = 1'b0;
        stable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < 10; j++) begin
            if (!(i == 0 && j == 0)) @(negedge clk);
            if (resetn !== 1'b1) aborted = 1'b1;
            if (j == 0) bits[i] = tx;
            else if (tx !== bits[i]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          if (tx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_frame: got frame data 0x%02h, expected no frame", bits[8:1]);
          end else begin
            expf = tx_q.pop_front();
            checkOutput("frame_start_bit", {31'd0, bits[0]}, 32'd0);
            checkOutput("frame_data", {24'd0, bits[8:1]}, {24'd0, expf.data});
            checkOutput("frame_stop_bit", {31'd0, bits[9]}, 32'd1);
            checkOutput("frame_bit_width", {31'd0, stable}, 32'd1);
            if (expf.contig) checkOutput("frame_contiguous", start_cyc - prev_start, 32'd100);
          end
          prev_start = start_cyc;
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin : stim
    int w;
    int c1;

    // Reset values while reset is held
    #50;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("reset_rdata", mem_rdata, 32'd0);
    #50;
    resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h4, 4'h0, 32'h0, 32'h2, w);
    checkOutput("status_read_latency", w, 32'd1);

    // Single byte 0x55
    tx_q.push_back('{data: 8'h55, contig: 1'b0});
    applyStimulus(32'h0, 4'h1, 32'h55, 32'h0, w);
    checkOutput("write_latency", w, 32'd1);
    checkOutput("tx_high_at_ready", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    checkOutput("tx_falls_two_after_accept", {31'd0, tx}, 32'd0);
    repeat (100) @(posedge clk);
    #1;
    applyStimulus(32'h4, 4'h0, 32'h0, 32'h2, w);

    // Burst of ten: nine without stall, FIFO full, tenth stalls
    for (int k = 0; k < 9; k++) begin
      tx_q.push_back('{data: k[7:0], contig: (k != 0)});
      applyStimulus(32'h0, 4'h1, k, 32'h0, w);
      if (k == 0) c1 = cyc;
      checkOutput("burst_no_stall", w, 32'd1);
    end
    applyStimulus(32'h4, 4'h0, 32'h0, 32'h5, w);
    tx_q.push_back('{data: 8'h09, contig: 1'b1});
    applyStimulus(32'h0, 4'h1, 32'h9, 32'h0, w);
    checkOutput("burst_stall_release_cycle", cyc - c1, 32'd102);
    for (int i = 0; i < 1500 && tx_q.size() != 0; i++) @(posedge clk);
    checkOutput("burst_drained", tx_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(32'h4, 4'h0, 32'h0, 32'h2, w);

    // STATUS write is acknowledged and ignored
    applyStimulus(32'h4, 4'hF, 32'hFFFF_FFFF, 32'h0, w);
    checkOutput("status_write_latency", w, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("status_write_tx_idle", {31'd0, tx}, 32'd1);
    applyStimulus(32'h4, 4'h0, 32'h0, 32'h2, w);

    // Reset during bit 4 of 0xA5 with three bytes queued
    applyStimulus(32'h0, 4'h1, 32'hA5, 32'h0, w);
    c1 = cyc;
    applyStimulus(32'h0, 4'h1, 32'h11, 32'h0, w);
    applyStimulus(32'h0, 4'h1, 32'h22, 32'h0, w);
    applyStimulus(32'h0, 4'h1, 32'h33, 32'h0, w);
    while (cyc < c1 + 55) @(posedge clk);
    #1;
    checkOutput("pre_reset_tx_bit4", {31'd0, tx}, 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("reset_async_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_async_ready", {31'd0, mem_ready}, 32'd0);
    #100;
    resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h4, 4'h0, 32'h0, 32'h2, w);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("post_reset_tx_idle", {31'd0, tx}, 32'd1);

    // TXDATA read returns zero
    applyStimulus(32'h0, 4'h0, 32'h0, 32'h0, w);
    checkOutput("txdata_read_latency", w, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("bus_scoreboard_empty", rd_q.size(), 32'd0);
    checkOutput("frame_scoreboard_empty", tx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter: the responder on the CPU's valid/ready data-memory bus that turns stores into 8N1 serial frames on a `tx` pin. It sits beside data RAM in `top` and gives the single-cycle core and its bench a console output. Stores go into a small FIFO that drains at the configured baud rate, so the core does not wait on bit timing unless the FIFO is full.

## Interface
- `SYSTEM_CLK`, 50_000_000, clock frequency in Hz
- `BAUDRATE`, 115200, line rate in bit/s
- `FIFO_DEPTH`, 8, TX FIFO entries (power of two, ≥2)

- `clk`  in  1  system clock; all state updates on rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `mem_valid`  in  1  request valid; held high by the initiator until `mem_ready`
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_wstrb`  in  4  byte strobes; 0 means read
- `mem_addr`  in  32  byte address; only bit 2 is decoded (block select is external)
- `mem_wdata`  in  32  write data
- `mem_rdata`  out  32  read data; valid while `mem_ready` is high
- `tx`  out  1  serial line, idle high

## Operation
- Register map:
  - offset 0x0 TXDATA: write pushes `mem_wdata[7:0]` when `mem_wstrb[0]`; reads return 0.
  - offset 0x4 STATUS (read-only): bit0 FIFO full, bit1 FIFO empty, bit2 transmitter busy (state ≠ IDLE); other bits 0. Writes are acknowledged and ignored.
- `DIV = SYSTEM_CLK / BAUDRATE` (integer truncation, e.g. 434). Elaboration fails if `DIV < 2`.
- Baud counter width is `$clog2(DIV)`. It counts `DIV-1` down to 0, then reloads.
- TX FSM:
  - IDLE: `tx=1`. If the FIFO is not empty, pop into the shift register and go to START.
  - START: `tx=0` for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0], LSB first. Shift every DIV cycles. After bit 7 go to STOP.
  - STOP: `tx=1` for DIV cycles. Then, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- FIFO: counter-based with `$clog2(FIFO_DEPTH)+1`-bit count. Pointers wrap modulo depth. Push and pop in the same cycle are both legal when neither full nor empty. A push is never accepted while full (no bypass).
- A write with no strobes is a read, and its data is ignored.

## Timing
- A request is accepted in a cycle where `mem_valid && !mem_ready` and it is not a TXDATA push while full. `mem_ready` is high the next cycle for exactly one cycle.
- A request is never accepted in the cycle `mem_ready` is high, which prevents double-accepting a held request.
- TXDATA write while full: `mem_ready` is withheld and the push is retried each cycle. It completes the cycle after the count drops below depth.
- STATUS read reflects registered state at the accept edge. `mem_rdata` is 0 whenever `mem_ready` is low.
- Push to idle transmitter:
  - data enters the FIFO at edge N, aligned with `mem_ready` rising;
  - pop happens at edge N+1;
  - `tx` falls after edge N+1.
- Frame is 10·DIV cycles. Back-to-back frames are contiguous.
- Reset values: `tx=1`, `mem_ready=0`, `mem_rdata=0`, FSM IDLE, counters 0, FIFO empty.
- Reset asserted mid-frame or mid-stall: `tx` goes to 1 immediately (asynchronously), queued data is discarded, and a pending request is dropped (never acknowledged).

## Structure
- Package `uart_tx_pkg`:
  - register offsets `TXDATA_OFFS=0`, `STATUS_OFFS=4`;
  - status bit indices;
  - enum `tx_state_t {IDLE, START, DATA, STOP}`.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`; ports `push`, `pop`, `din`, `dout`, `full`, `empty`), same clock and reset.
- Top-level holds bus decode, baud counter, FSM, and shift register.

## Test plan
Benches use `SYSTEM_CLK=1000`, `BAUDRATE=100`, so DIV=10.
- Reset: hold `resetn=0` for 100 ns. Expect `tx=1`, `mem_ready=0`, `mem_rdata=0`. A STATUS read then returns 0x2.
- Single write 0x55 to TXDATA:
  - `mem_ready` pulses once, one cycle after accept;
  - `tx` falls two cycles after accept;
  - line shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 10 cycles;
  - STATUS reads 0x2 after 100 cycles.
- Burst of 10 writes 0x00–0x09:
  - the first 9 complete without stall (one in flight plus 8 queued);
  - the 10th stalls until the first frame ends, then completes;
  - STATUS bit0 reads 1 during the stall;
  - all 10 frames are contiguous and in order.
- STATUS write with 0xFFFFFFFF: acknowledged in one cycle, no FIFO change, `tx` stays idle.
- Reset mid-frame after bit 3 of 0xA5 with 3 bytes queued:
  - `tx` returns to 1 without waiting for a clock;
  - after release, STATUS reads 0x2 and no further frames appear.
- Read TXDATA: returns 0x00000000 with a one-cycle `mem_ready`.
